div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Execute-stage sequencer for the shared radix-2 iterative divider in the MIPS core.
- Accepts DIV/DIVU from the EX stage and stalls the pipeline while the divider runs.
- Drives the divider's operand handshake and result handshake, and aborts the divider on exception flush.
- Holds the HI/LO result until the EX stage advances.
- Handles divide-by-zero locally without launching the divider.

Parameters:
DIV0_FAST, 1, 1: b==0 bypasses the divider; 0: b==0 is launched like any other operand.
DIV0_LO, 32'hFFFF_FFFF, LO value returned on the divide-by-zero fast path (HI returns the dividend a).

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
flush  in  1  exception flush of the EX stage; kills any in-flight divide
ex_div_valid  in  1  EX stage holds a DIV/DIVU instruction
ex_div_sign  in  1  1 = DIV (signed), 0 = DIVU
ex_a  in  32  dividend
ex_b  in  32  divisor
pipe_hold  in  1  EX cannot advance this cycle for reasons outside this block
div_stall  out  1  request EX stall: result not yet available
res_valid  out  1  hi_out/lo_out hold the result for the current EX instruction
hi_out  out  32  remainder
lo_out  out  32  quotient
div_rst  out  1  divider reset
div_a  out  32  divider dividend (registered)
div_b  out  32  divider divisor (registered)
div_sign  out  1  divider sign (registered); stable for the whole operation
div_opn_valid  out  1  operand valid to divider
div_res_ready  out  1  ready for divider result
div_res_valid  in  1  divider result valid
div_result  in  64  {remainder, quotient} from divider

Behaviour:
- States: IDLE, LAUNCH, BUSY, DONE.
- Reset values: state IDLE; res_valid 0; div_opn_valid 0; div_res_ready 0; hi_out, lo_out, div_a, div_b 0; div_sign 0.
- div_rst = rst | (flush & state ∈ {LAUNCH, BUSY}). This is combinational and is sampled synchronously by the divider.
- div_stall = ex_div_valid & (state != DONE) & ~flush.
- IDLE, on ex_div_valid & ~flush:
  - Capture ex_a, ex_b, ex_sign into div_a, div_b, div_sign.
  - If DIV0_FAST and ex_b==0: set hi_out = ex_a, lo_out = DIV0_LO, go to DONE.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - div_opn_valid = 1 for exactly this cycle. The divider is guaranteed idle with no pending result, so the operands are accepted at this edge.
  - Go to BUSY.
- BUSY:
  - div_res_ready = 1.
  - On div_res_valid: capture hi_out = div_result[63:32], lo_out = div_result[31:0], go to DONE. The divider's valid clears at the same edge.
- DONE:
  - res_valid = 1, div_stall = 0.
  - If ~pipe_hold: go to IDLE. The next cycle's ex_div_valid belongs to the next instruction, so the same instruction is never relaunched.
  - If pipe_hold: stay in DONE, with hi_out/lo_out held stable.
- Flush:
  - In any state, flush forces IDLE at the next edge, clears res_valid, and leaves hi_out/lo_out unchanged.
  - In LAUNCH/BUSY it additionally pulses div_rst, so the divider abandons its computation and drops any pending div_res_valid.
  - flush in IDLE with ex_div_valid: no capture, no launch.
- Flush and div_res_valid in the same BUSY cycle: flush wins; the result is discarded.
- Latency with an idle divider, ex_div_valid first seen in cycle 0:
  - LAUNCH in cycle 1.
  - Divider result visible in cycle 34.
  - DONE in cycle 35.
  - div_stall high for cycles 0–34 (35 cycles).
- Divide-by-zero fast path: div_stall high only in cycle 0; res_valid in cycle 1.
- Arithmetic: the controller does no sign correction; the divider result is passed through unchanged.
  - Signed 0x8000_0000 / 0xFFFF_FFFF yields lo = 0x8000_0000, hi = 0.
- rst mid-operation: all state returns to reset values and div_rst is asserted.

Test Plan:
- DIVU a=100, b=7, pipe_hold=0 -> div_stall high 35 cycles; then res_valid=1 with lo=14, hi=2; single div_opn_valid pulse.
- DIV a=-7 (0xFFFF_FFF9), b=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); div_sign stays 1 throughout BUSY.
- DIV a=0x8000_0000, b=0xFFFF_FFFF -> lo=0x8000_0000, hi=0, no hang.
- DIVU a=5, b=0 with DIV0_FAST=1 -> no div_opn_valid; res_valid in cycle 1 with hi=5, lo=0xFFFF_FFFF.
- DIVU a=1000, b=3: flush in cycle 10 -> div_rst pulse in cycle 10, state IDLE, res_valid never set. Then DIVU a=9, b=3 issued in cycle 12 -> lo=3, hi=0 after 35 stall cycles.
- DIVU a=20, b=6 with pipe_hold=1 for 5 cycles after DONE -> res_valid, hi=2, lo=3 held for 6 cycles; exactly one launch. Then back-to-back DIVU a=8, b=2 -> second launch, lo=4.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
//
// Execute-stage sequencer for the shared radix-2 iterative divider.
// A DIV/DIVU held in EX is captured, launched to the divider with a single
// operand-valid pulse, and the pipeline is stalled until the {HI, LO} result
// comes back. The result is then held until EX advances. A zero divisor can be
// answered locally (DIV0_FAST) without ever starting the divider. An exception
// flush kills whatever is in flight and resets the divider if it was running.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             EX-stage exception flush
//   ex_div_valid      EX holds a DIV/DIVU
//   ex_div_sign       1 = DIV (signed), 0 = DIVU
//   ex_a, ex_b        dividend / divisor from EX
//   pipe_hold         EX held for reasons outside this block
//   div_stall         stall request to the pipeline (combinational)
//   res_valid         hi_out/lo_out hold the result for the EX instruction
//   hi_out, lo_out    remainder / quotient
//   div_rst           divider reset (combinational, sampled synchronously)
//   div_a, div_b      registered operands to the divider
//   div_sign          registered sign mode to the divider
//   div_opn_valid     operand valid to the divider
//   div_res_ready     ready for the divider result
//   div_res_valid     divider result valid
//   div_result        {remainder, quotient} from the divider
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
  parameter bit          DIV0_FAST = 1'b1,
  parameter logic [31:0] DIV0_LO   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_div_valid,
  input  logic        ex_div_sign,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic        pipe_hold,
  output logic        div_stall,
  output logic        res_valid,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        div_rst,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_sign,
  output logic        div_opn_valid,
  output logic        div_res_ready,
  input  logic        div_res_valid,
  input  logic [63:0] div_result
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;

  // The divider only holds live work in LAUNCH/BUSY, so only a flush there
  // needs to reset it; a flush elsewhere leaves the divider untouched.
  assign div_rst   = rst | (flush & ((state == LAUNCH) | (state == BUSY)));

  // Once the result is held in DONE the pipeline is free to move; a flush
  // kills the instruction so there is nothing left to wait for.
  assign div_stall = ex_div_valid & (state != DONE) & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      res_valid     <= 1'b0;
      div_opn_valid <= 1'b0;
      div_res_ready <= 1'b0;
      hi_out        <= '0;
      lo_out        <= '0;
      div_a         <= '0;
      div_b         <= '0;
      div_sign      <= 1'b0;
    end else if (flush) begin
      // hi_out/lo_out keep their old contents; only the handshake state dies.
      state         <= IDLE;
      res_valid     <= 1'b0;
      div_opn_valid <= 1'b0;
      div_res_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_div_valid) begin
            div_a    <= ex_a;
            div_b    <= ex_b;
            div_sign <= ex_div_sign;
            if (DIV0_FAST && (ex_b == 32'd0)) begin
              hi_out    <= ex_a;
              lo_out    <= DIV0_LO;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              div_opn_valid <= 1'b1;
              state         <= LAUNCH;
            end
          end
        end

        LAUNCH: begin
          // The divider is idle here, so the single-cycle pulse is always taken.
          div_opn_valid <= 1'b0;
          div_res_ready <= 1'b1;
          state         <= BUSY;
        end

        BUSY: begin
          if (div_res_valid) begin
            hi_out        <= div_result[63:32];
            lo_out        <= div_result[31:0];
            div_res_ready <= 1'b0;
            res_valid     <= 1'b1;
            state         <= DONE;
          end
        end

        DONE: begin
          // Leaving DONE on the advancing edge means the next ex_div_valid seen
          // in IDLE is a new instruction, never a relaunch of this one.
          if (!pipe_hold) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ex_div_valid = 1'b0;
  logic        ex_div_sign = 1'b0;
  logic [31:0] ex_a = '0;
  logic [31:0] ex_b = '0;
  logic        pipe_hold = 1'b0;
  logic        div_stall;
  logic        res_valid;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_rst;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_sign;
  logic        div_opn_valid;
  logic        div_res_ready;
  logic        div_res_valid;
  logic [63:0] div_result;

  always #5 clk = ~clk;

  div_issue_ctrl #(.DIV0_FAST(1'b1), .DIV0_LO(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_div_valid(ex_div_valid), .ex_div_sign(ex_div_sign),
    .ex_a(ex_a), .ex_b(ex_b), .pipe_hold(pipe_hold),
    .div_stall(div_stall), .res_valid(res_valid),
    .hi_out(hi_out), .lo_out(lo_out), .div_rst(div_rst),
    .div_a(div_a), .div_b(div_b), .div_sign(div_sign),
    .div_opn_valid(div_opn_valid), .div_res_ready(div_res_ready),
    .div_res_valid(div_res_valid), .div_result(div_result)
  );

  int checks = 0;
  int errors = 0;

  // Architectural divide: truncating quotient, remainder takes the dividend's
  // sign; zero divisor answers {a, all-ones}.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Iterative divider stand-in: accepts operands when idle, delivers the
  // result 33 edges later, holds it until taken, abandons all on div_rst.
  logic        dv_busy = 1'b0;
  logic        dv_valid = 1'b0;
  int          dv_cnt = 0;
  logic [63:0] dv_res = '0;
  logic [63:0] noise = '0;

  always @(posedge clk) begin
    noise <= {$urandom(), $urandom()};
    if (div_rst) begin
      dv_busy  <= 1'b0;
      dv_valid <= 1'b0;
      dv_cnt   <= 0;
    end else begin
      if (dv_valid && div_res_ready) dv_valid <= 1'b0;
      if (div_opn_valid && !dv_busy && !dv_valid) begin
        dv_busy <= 1'b1;
        dv_cnt  <= 32;
        dv_res  <= ref_div(div_sign, div_a, div_b);
      end else if (dv_busy) begin
        if (dv_cnt == 1) begin
          dv_busy  <= 1'b0;
          dv_valid <= 1'b1;
        end else begin
          dv_cnt <= dv_cnt - 1;
        end
      end
    end
  end

  assign div_res_valid = dv_valid;
  assign div_result    = dv_valid ? dv_res : noise;

  int launches = 0;
  always @(posedge clk) if (div_opn_valid) launches <= launches + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one instruction starting at the current negedge and follow it until
  // EX advances past it. Returns at the negedge after the advancing edge.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output int stall_n, output int res_n,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int bad);
    int  guard;
    bit  last;
    guard = 0; last = 0;
    stall_n = 0; res_n = 0; bad = 0; hi = '0; lo = '0;
    ex_div_valid = 1'b1; ex_div_sign = s; ex_a = a; ex_b = b; pipe_hold = 1'b0;
    while (!last && guard < 200) begin
      guard++;
      if (res_valid) begin
        res_n++;
        if (res_n == 1) begin
          hi = hi_out; lo = lo_out;
        end else if (hi_out !== hi || lo_out !== lo) begin
          bad++;
        end
        pipe_hold = (res_n <= hold);
        last = (res_n > hold);
        #1;
        if (div_stall) bad++;
      end else begin
        #1;
        if (div_stall) stall_n++;
        else bad++;
        if (div_res_ready && (div_sign !== s || div_a !== a || div_b !== b)) bad++;
      end
      @(negedge clk);
    end
    pipe_hold = 1'b0;
    chk("op_timeout", guard >= 200, 0);
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
    int          nlaunch;
  } vec_t;

  vec_t tbl[7];

  initial begin : main
    int          st, rn, bd, l0, guard;
    logic [31:0] h, l, ph, pl;
    logic [63:0] e;
    logic        rs;
    logic [31:0] ra, rb;
    int          rh;

    tbl[0] = '{1'b0, 32'd100,        32'd7,          0, 32'd2,          32'd14,         35, 1};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          0, 32'hFFFF_FFFF,  32'hFFFF_FFFD,  35, 1};
    tbl[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  0, 32'd0,          32'h8000_0000,  35, 1};
    tbl[3] = '{1'b0, 32'd5,          32'd0,          0, 32'd5,          32'hFFFF_FFFF,  1,  0};
    tbl[4] = '{1'b0, 32'd20,         32'd6,          5, 32'd2,          32'd3,          35, 1};
    tbl[5] = '{1'b0, 32'd8,          32'd2,          0, 32'd0,          32'd4,          35, 1};
    tbl[6] = '{1'b1, 32'hFFFF_FFF0,  32'd0,          1, 32'hFFFF_FFF0,  32'hFFFF_FFFF,  1,  0};

    // Reset state
    repeat (3) @(negedge clk);
    #1 chk("rst_div_rst", div_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_opn_valid", div_opn_valid, 0);
    chk("rst_res_ready", div_res_ready, 0);
    chk("rst_hi_lo", {hi_out, lo_out}, 64'd0);
    chk("rst_div_ab", {div_a, div_b}, 64'd0);
    chk("rst_div_sign", div_sign, 0);
    chk("rst_div_rst_off", div_rst, 0);
    chk("rst_stall", div_stall, 0);
    @(negedge clk);

    // Directed vectors, issued back to back
    for (int i = 0; i < 7; i++) begin
      l0 = launches;
      run_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].hold, st, rn, h, l, bd);
      chk($sformatf("vec%0d_hi", i), h, tbl[i].hi);
      chk($sformatf("vec%0d_lo", i), l, tbl[i].lo);
      chk($sformatf("vec%0d_stall", i), st, tbl[i].stall);
      chk($sformatf("vec%0d_launch", i), launches - l0, tbl[i].nlaunch);
      chk($sformatf("vec%0d_res_cycles", i), rn, tbl[i].hold + 1);
      chk($sformatf("vec%0d_stability", i), bd, 0);
    end
    ex_div_valid = 1'b0;
    @(negedge clk);

    // Flush in cycle 10 of DIVU 1000/3, then DIVU 9/3 in cycle 12
    l0 = launches;
    ex_div_valid = 1'b1; ex_div_sign = 1'b0; ex_a = 32'd1000; ex_b = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_div_rst", div_rst, 1);
    chk("flush_stall", div_stall, 0);
    @(negedge clk);
    flush = 1'b0; ex_div_valid = 1'b0;
    #1;
    chk("flush_idle_ready", div_res_ready, 0);
    chk("flush_res_valid", res_valid, 0);
    chk("flush_div_rst_off", div_rst, 0);
    @(negedge clk);
    run_op(1'b0, 32'd9, 32'd3, 0, st, rn, h, l, bd);
    chk("postflush_hilo", {h, l}, {32'd0, 32'd3});
    chk("postflush_stall", st, 35);
    chk("postflush_launches", launches - l0, 2);
    chk("postflush_stability", bd, 0);
    ph = hi_out; pl = lo_out;

    // Flush in the same BUSY cycle as div_res_valid: result discarded
    ex_div_valid = 1'b1; ex_div_sign = 1'b0; ex_a = 32'd50; ex_b = 32'd7;
    guard = 0;
    while (!div_res_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("race_result_seen", guard < 100, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; ex_div_valid = 1'b0;
    #1;
    chk("race_res_valid", res_valid, 0);
    chk("race_hilo_kept", {hi_out, lo_out}, {ph, pl});
    chk("race_divider_dropped", div_res_valid, 0);
    repeat (3) @(negedge clk);
    chk("race_res_valid_later", res_valid, 0);

    // Reset mid-operation
    ex_div_valid = 1'b1; ex_div_sign = 1'b1; ex_a = 32'd77; ex_b = 32'd5;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1 chk("midrst_div_rst", div_rst, 1);
    @(negedge clk);
    rst = 1'b0; ex_div_valid = 1'b0;
    #1;
    chk("midrst_regs", {hi_out, lo_out, div_a}, 96'd0);
    chk("midrst_ctrl", {res_valid, div_res_ready, div_opn_valid, div_sign}, 4'd0);
    @(negedge clk);
    run_op(1'b0, 32'd77, 32'd5, 0, st, rn, h, l, bd);
    chk("midrst_rerun", {h, l}, {32'd2, 32'd15});
    ex_div_valid = 1'b0;
    @(negedge clk);

    // Flush in IDLE alongside ex_div_valid: no capture, no launch
    l0 = launches;
    flush = 1'b1; ex_div_valid = 1'b1; ex_a = 32'd123; ex_b = 32'd4;
    @(negedge clk);
    flush = 1'b0; ex_div_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("idleflush_launch", launches - l0, 0);
    chk("idleflush_no_capture", div_a, 32'd77);
    chk("idleflush_res_valid", res_valid, 0);

    // Flush while a fast-path result is held in DONE
    ex_div_valid = 1'b1; ex_div_sign = 1'b0; ex_a = 32'd9; ex_b = 32'd0; pipe_hold = 1'b1;
    @(negedge clk);
    chk("donefl_res_valid", res_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; ex_div_valid = 1'b0; pipe_hold = 1'b0;
    chk("donefl_cleared", res_valid, 0);
    chk("donefl_hi_kept", hi_out, 32'd9);
    @(negedge clk);

    // Randomized operations against the arithmetic reference
    for (int k = 0; k < 30; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom();
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom();
      endcase
      rh = $urandom_range(0, 2);
      e = ref_div(rs, ra, rb);
      l0 = launches;
      run_op(rs, ra, rb, rh, st, rn, h, l, bd);
      chk($sformatf("rnd%0d_hilo", k), {h, l}, e);
      chk($sformatf("rnd%0d_stall", k), st, (rb == 0) ? 1 : 35);
      chk($sformatf("rnd%0d_launch", k), launches - l0, (rb == 0) ? 0 : 1);
      chk($sformatf("rnd%0d_misc", k), {rn, bd}, {rh + 1, 32'd0});
      if ($urandom_range(0, 1) == 1) begin
        ex_div_valid = 1'b0;
        @(negedge clk);
      end
    end
    ex_div_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
